// File: rtl/dsp_pkg.sv
// APU DSP timebase shared definitions: rate period table and sample framing.
// Latency: n/a (constants, types and a pure helper function only).
// Backpressure: n/a.
package dsp_pkg;

    localparam int SAMPLE_PHASES = 64;

    // Period multiplier selector; M_NONE marks the "never fires" rate.
    typedef enum logic [1:0] {
        M_NONE = 2'd0,
        M_1    = 2'd1,
        M_3    = 2'd2,
        M_5    = 2'd3
    } m_sel_t;

    // Rate period = m * 2^k samples.
    typedef struct packed {
        m_sel_t     m_sel;
        logic [3:0] k;
    } rate_period_t;

    localparam rate_period_t RATE_TABLE [0:31] = '{
        '{M_NONE, 4'd0},
        '{M_1, 4'd11}, '{M_3, 4'd9}, '{M_5, 4'd8},
        '{M_1, 4'd10}, '{M_3, 4'd8}, '{M_5, 4'd7},
        '{M_1, 4'd9},  '{M_3, 4'd7}, '{M_5, 4'd6},
        '{M_1, 4'd8},  '{M_3, 4'd6}, '{M_5, 4'd5},
        '{M_1, 4'd7},  '{M_3, 4'd5}, '{M_5, 4'd4},
        '{M_1, 4'd6},  '{M_3, 4'd4}, '{M_5, 4'd3},
        '{M_1, 4'd5},  '{M_3, 4'd3}, '{M_5, 4'd2},
        '{M_1, 4'd4},  '{M_3, 4'd2}, '{M_5, 4'd1},
        '{M_1, 4'd3},  '{M_3, 4'd1}, '{M_5, 4'd0},
        '{M_1, 4'd2},  '{M_3, 4'd0}, '{M_1, 4'd1},
        '{M_1, 4'd0}
    };

    // Mask selecting the low k bits of a binary counter (k = 0 gives an empty mask).
    function automatic logic [10:0] low_mask(input logic [3:0] k);
        logic [11:0] one_hot;
        one_hot  = 12'd1 << k;
        low_mask = 11'(one_hot - 12'd1);
    endfunction

endpackage

// File: rtl/dsp_sample_clock_if.sv
// Sample-clock bundle: cpu_en/rate_id in, sample strobe, step index and rate hit out.
// Latency: n/a (signal grouping only).
// Backpressure: none; cpu_en is a free-running enable, not a handshake.
interface dsp_sample_clock_if;
    logic       cpu_en;     // APU clock enable
    logic [4:0] rate_id;    // rate to poll this cycle
    logic       exe_32khz;  // high while phase == 63
    logic [4:0] step;       // voice pipeline step, phase[5:1]
    logic       step_odd;   // phase[0]
    logic       rate_hit;   // selected rate fires on the tick ending this period

    modport master (
        output cpu_en, rate_id,
        input  exe_32khz, step, step_odd, rate_hit
    );

    modport slave (
        input  cpu_en, rate_id,
        output exe_32khz, step, step_odd, rate_hit
    );
endinterface

// File: rtl/dsp_rate_poll.sv
// Rate decode: does the selected rate fire on the current sample, given shared counters.
// Latency: purely combinational.
// Backpressure: none.
// Ports: rate_id in; cnt1/pre3/cnt3/pre5/cnt5 shared counter state in; rate_hit out.
module dsp_rate_poll
    import dsp_pkg::*;
(
    input  logic [4:0]  rate_id,
    input  logic [10:0] cnt1,
    input  logic [1:0]  pre3,
    input  logic [8:0]  cnt3,
    input  logic [2:0]  pre5,
    input  logic [7:0]  cnt5,
    output logic        rate_hit
);

    rate_period_t sel;
    logic [10:0]  mask;

    // Period m*2^k fires when the m-prescaler sits at zero and the low k bits
    // of the matching binary counter are zero.
    always_comb begin
        sel      = RATE_TABLE[rate_id];
        mask     = low_mask(sel.k);
        rate_hit = 1'b0;
        case (sel.m_sel)
            M_1:     rate_hit = ((cnt1 & mask) == 11'd0);
            M_3:     rate_hit = (pre3 == 2'd0) && ((cnt3 & mask[8:0]) == 9'd0);
            M_5:     rate_hit = (pre5 == 3'd0) && ((cnt5 & mask[7:0]) == 8'd0);
            default: rate_hit = 1'b0;
        endcase
    end

endmodule

// File: rtl/dsp_sample_clock.sv
// APU DSP timebase: 64-enable sample period, 32 kHz strobe, step index, shared rate counters.
// Latency: state updates on the clk edge with cpu_en=1; rate_hit is combinational from state.
// Backpressure: none; cpu_en=0 freezes everything, exe_32khz must be qualified with cpu_en.
// Ports: clk, reset (sync, active-high); dsp (slave): cpu_en, rate_id in;
//        exe_32khz, step, step_odd, rate_hit out.
module dsp_sample_clock
    import dsp_pkg::*;
#(
    parameter int PERIOD_EN = SAMPLE_PHASES  // only 64 is supported: step = phase/2
) (
    input  logic                clk,
    input  logic                reset,
    dsp_sample_clock_if.slave   dsp
);

    localparam logic [5:0] LAST_PHASE = 6'(PERIOD_EN - 1);

    logic [5:0]  phase;
    logic [10:0] cnt1;
    logic [1:0]  pre3;
    logic [8:0]  cnt3;
    logic [2:0]  pre5;
    logic [7:0]  cnt5;
    logic        tick;

    assign tick = dsp.cpu_en && (phase == LAST_PHASE);

    always_ff @(posedge clk) begin
        if (reset) begin
            phase <= 6'd0;
            cnt1  <= 11'd0;
            pre3  <= 2'd0;
            cnt3  <= 9'd0;
            pre5  <= 3'd0;
            cnt5  <= 8'd0;
        end else if (dsp.cpu_en) begin
            phase <= phase + 6'd1;   // natural 63 -> 0 wrap
            // Rate counters advance on the same edge that consumes the tick, so
            // rate_hit seen alongside the tick reflects the pre-update state.
            if (tick) begin
                cnt1 <= cnt1 + 11'd1;
                if (pre3 == 2'd2) begin
                    pre3 <= 2'd0;
                    cnt3 <= cnt3 + 9'd1;
                end else begin
                    pre3 <= pre3 + 2'd1;
                end
                if (pre5 == 3'd4) begin
                    pre5 <= 3'd0;
                    cnt5 <= cnt5 + 8'd1;
                end else begin
                    pre5 <= pre5 + 3'd1;
                end
            end
        end
    end

    assign dsp.exe_32khz = (phase == LAST_PHASE);
    assign dsp.step      = phase[5:1];
    assign dsp.step_odd  = phase[0];

    dsp_rate_poll u_rate_poll (
        .rate_id  (dsp.rate_id),
        .cnt1     (cnt1),
        .pre3     (pre3),
        .cnt3     (cnt3),
        .pre5     (pre5),
        .cnt5     (cnt5),
        .rate_hit (dsp.rate_hit)
    );

endmodule

// File: tb/tb_dsp_sample_clock.sv
module tb_dsp_sample_clock;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dsp_sample_clock_if dif ();

    dsp_sample_clock #(.PERIOD_EN(64)) dut (
        .clk   (clk),
        .reset (reset),
        .dsp   (dif)
    );

    // Standalone decoder for counter states too far away to reach in simulation.
    logic [4:0]  p_rid;
    logic [10:0] p_cnt1;
    logic [1:0]  p_pre3;
    logic [8:0]  p_cnt3;
    logic [2:0]  p_pre5;
    logic [7:0]  p_cnt5;
    logic        p_hit;

    dsp_rate_poll u_poll (
        .rate_id  (p_rid),
        .cnt1     (p_cnt1),
        .pre3     (p_pre3),
        .cnt3     (p_cnt3),
        .pre5     (p_pre5),
        .cnt5     (p_cnt5),
        .rate_hit (p_hit)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Sample periods per rate_id, straight from m * 2^k.
    int periods [32] = '{0, 2048, 1536, 1280, 1024, 768, 640, 512, 384, 320, 256,
                         192, 160, 128, 96, 80, 64, 48, 40, 32, 24, 20, 16, 12,
                         10, 8, 6, 5, 4, 3, 2, 1};

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Model: count of enables since reset; everything follows by arithmetic.
    int unsigned m_en    = 0;
    bit          m_valid = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_en    <= 0;
            m_valid <= 1'b1;
        end else if (dif.cpu_en) begin
            m_en <= m_en + 1;
        end
    end

    always @(negedge clk) begin : compare
        int ph;
        int t;
        int exp_hit;
        if (m_valid) begin
            ph = int'(m_en % 64);
            t  = int'(m_en / 64);
            exp_hit = 0;
            if (dif.rate_id != 5'd0)
                exp_hit = ((t % periods[dif.rate_id]) == 0) ? 1 : 0;
            check("model exe_32khz", 32'(dif.exe_32khz), 32'(ph == 63));
            check("model step",      32'(dif.step),      32'(ph / 2));
            check("model step_odd",  32'(dif.step_odd),  32'(ph % 2));
            check("model rate_hit",  32'(dif.rate_hit),  32'(exp_hit));
        end
    end

    int hits[$];
    int expq[$];

    task automatic cyc(input logic en, input logic [4:0] rid);
        dif.cpu_en  = en;
        dif.rate_id = rid;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        dif.cpu_en  = 1'b1;   // reset must win over a concurrent enable
        @(posedge clk);
        #1;
        reset       = 1'b0;
        dif.cpu_en  = 1'b0;
    endtask

    task automatic probe(string name, input logic [4:0] rid, input logic exp);
        dif.rate_id = rid;
        #1;
        check(name, 32'(dif.rate_hit), 32'(exp));
    endtask

    // Runs n_ticks sample ticks, logging which tick indices hit for rate fixed_rid.
    // With mix set, cpu_en gaps and a different rate_id on non-tick cycles are added.
    task automatic run(input int n_ticks, input logic [4:0] fixed_rid, input bit mix);
        int done;
        int guard;
        logic en;
        logic [4:0] rid;
        done  = 0;
        guard = 0;
        hits.delete();
        while (done < n_ticks && guard < n_ticks * 80 + 200) begin
            en  = mix ? ($urandom_range(7) != 0) : 1'b1;
            rid = fixed_rid;
            if (mix && !(en && (m_en % 64) == 63))
                rid = 5'($urandom_range(31));
            dif.cpu_en  = en;
            dif.rate_id = rid;
            #2;
            if (en && dif.exe_32khz) begin
                if (dif.rate_hit) hits.push_back(done);
                done++;
            end
            @(posedge clk);
            #1;
            guard++;
        end
        check("tick count within cycle budget", 32'(done), 32'(n_ticks));
    endtask

    task automatic check_hits(string name);
        check({name, " hit count"}, 32'(hits.size()), 32'(expq.size()));
        for (int i = 0; i < expq.size() && i < hits.size(); i++)
            check({name, " hit tick"}, 32'(hits[i]), 32'(expq[i]));
    endtask

    task automatic poll_vec(string name, input logic [4:0] rid, input logic [10:0] c1,
                            input logic [1:0] p3, input logic [8:0] c3,
                            input logic [2:0] p5, input logic [7:0] c5, input logic exp);
        p_rid = rid; p_cnt1 = c1; p_pre3 = p3; p_cnt3 = c3; p_pre5 = p5; p_cnt5 = c5;
        #1;
        check(name, 32'(p_hit), 32'(exp));
    endtask

    initial begin
        reset       = 1'b0;
        dif.cpu_en  = 1'b0;
        dif.rate_id = 5'd0;

        // Reset state.
        do_reset();
        check("reset exe_32khz", 32'(dif.exe_32khz), 0);
        check("reset step",      32'(dif.step),      0);
        check("reset step_odd",  32'(dif.step_odd),  0);
        probe("reset hit rate1",  5'd1,  1'b1);
        probe("reset hit rate31", 5'd31, 1'b1);
        probe("reset hit rate0",  5'd0,  1'b0);

        // First period: strobe rises after 63 enables.
        for (int i = 0; i < 62; i++) cyc(1'b1, 5'd31);
        check("62 en exe low",  32'(dif.exe_32khz), 0);
        check("62 en step",     32'(dif.step),      31);
        check("62 en step_odd", 32'(dif.step_odd),  0);
        cyc(1'b1, 5'd31);
        check("63 en exe high", 32'(dif.exe_32khz), 1);
        check("63 en step_odd", 32'(dif.step_odd),  1);
        probe("tick0 hit rate2", 5'd2, 1'b1);

        // Tick consumed; one sample elapsed.
        cyc(1'b1, 5'd31);
        check("64 en exe low", 32'(dif.exe_32khz), 0);
        probe("sample1 rate31", 5'd31, 1'b1);
        probe("sample1 rate30", 5'd30, 1'b0);

        // Freeze mid-period.
        for (int i = 0; i < 21; i++) cyc(1'b1, 5'd31);
        for (int i = 0; i < 100; i++) cyc(1'b0, 5'(i % 32));
        check("frozen step",     32'(dif.step),      10);
        check("frozen step_odd", 32'(dif.step_odd),  1);
        check("frozen exe",      32'(dif.exe_32khz), 0);
        probe("frozen rate29", 5'd29, 1'b0);
        probe("frozen rate31", 5'd31, 1'b1);
        cyc(1'b1, 5'd0);
        check("resume step",     32'(dif.step),     11);
        check("resume step_odd", 32'(dif.step_odd), 0);

        // Short-period rates.
        do_reset(); run(10, 5'd29, 1'b0); expq = {0, 3, 6, 9};  check_hits("rate29");
        do_reset(); run(11, 5'd27, 1'b0); expq = {0, 5, 10};    check_hits("rate27");
        do_reset(); run(8, 5'd31, 1'b0);
        expq.delete();
        for (int i = 0; i < 8; i++) expq.push_back(i);
        check_hits("rate31");
        do_reset(); run(20, 5'd0, 1'b0);
        check("rate0 hit count", 32'(hits.size()), 0);

        // Reset together with cpu_en at phase 40 after some elapsed samples.
        do_reset(); run(5, 5'd31, 1'b0);
        for (int i = 0; i < 40; i++) cyc(1'b1, 5'd0);
        check("pre-reset step", 32'(dif.step), 20);
        do_reset();
        check("mid reset step", 32'(dif.step), 0);
        probe("mid reset rate29", 5'd29, 1'b1);
        for (int i = 0; i < 62; i++) cyc(1'b1, 5'd0);
        check("post reset 62 en exe", 32'(dif.exe_32khz), 0);
        cyc(1'b1, 5'd0);
        check("post reset 63 en exe", 32'(dif.exe_32khz), 1);
        probe("post reset tick rate1",  5'd1,  1'b1);
        probe("post reset tick rate2",  5'd2,  1'b1);
        probe("post reset tick rate3",  5'd3,  1'b1);
        probe("post reset tick rate29", 5'd29, 1'b1);
        probe("post reset tick rate0",  5'd0,  1'b0);

        // Long mixed run: enable gaps, rate_id changing every cycle, rate 7 on ticks.
        do_reset(); run(520, 5'd7, 1'b1); expq = {0, 512}; check_hits("rate7 mixed");

        // Decoder at counter states near wraparound.
        poll_vec("poll r1 c1=0",       5'd1,  11'd0,    2'd0, 9'd0,   3'd0, 8'd0,   1'b1);
        poll_vec("poll r1 c1=1024",    5'd1,  11'd1024, 2'd0, 9'd0,   3'd0, 8'd0,   1'b0);
        poll_vec("poll r4 c1=1024",    5'd4,  11'd1024, 2'd0, 9'd0,   3'd0, 8'd0,   1'b1);
        poll_vec("poll r1 c1=2047",    5'd1,  11'd2047, 2'd0, 9'd0,   3'd0, 8'd0,   1'b0);
        poll_vec("poll r2 c3=0",       5'd2,  11'd5,    2'd0, 9'd0,   3'd1, 8'd3,   1'b1);
        poll_vec("poll r2 c3=256",     5'd2,  11'd0,    2'd0, 9'd256, 3'd0, 8'd0,   1'b0);
        poll_vec("poll r2 pre3=1",     5'd2,  11'd0,    2'd1, 9'd0,   3'd0, 8'd0,   1'b0);
        poll_vec("poll r5 c3=256",     5'd5,  11'd0,    2'd0, 9'd256, 3'd0, 8'd0,   1'b1);
        poll_vec("poll r29 c3=511",    5'd29, 11'd7,    2'd0, 9'd511, 3'd2, 8'd1,   1'b1);
        poll_vec("poll r3 c5=0",       5'd3,  11'd9,    2'd2, 9'd3,   3'd0, 8'd0,   1'b1);
        poll_vec("poll r3 c5=128",     5'd3,  11'd0,    2'd0, 9'd0,   3'd0, 8'd128, 1'b0);
        poll_vec("poll r6 c5=128",     5'd6,  11'd0,    2'd0, 9'd0,   3'd0, 8'd128, 1'b1);
        poll_vec("poll r27 pre5=4",    5'd27, 11'd0,    2'd0, 9'd0,   3'd4, 8'd0,   1'b0);
        poll_vec("poll r27 c5=255",    5'd27, 11'd0,    2'd0, 9'd0,   3'd0, 8'd255, 1'b1);
        poll_vec("poll r0 zero state", 5'd0,  11'd0,    2'd0, 9'd0,   3'd0, 8'd0,   1'b0);
        poll_vec("poll r31 any",       5'd31, 11'd1234, 2'd1, 9'd77,  3'd3, 8'd9,   1'b1);
        poll_vec("poll r30 c1=2047",   5'd30, 11'd2047, 2'd0, 9'd0,   3'd0, 8'd0,   1'b0);
        poll_vec("poll r28 c1=2044",   5'd28, 11'd2044, 2'd0, 9'd0,   3'd0, 8'd0,   1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
